wave_display: RTL and testbench

- Downstream consumer of the waveform store, running in the LCD pixel clock domain.
- For each pixel coordinate from the LCD driver, it does two things:
  - fetches the stored sample for that column over the wave read port;
  - renders a 300x256 waveform window as RGB565: connected trace, trigger-level line, dotted grid and background.
- Signals frame completion on lcd_wr_over so the capture side can re-arm.

---
 rtl/wave_display_if.sv | 19 +
 rtl/wave_display.sv | 193 +++++++++++++++++++
 tb/tb_wave_display.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_display_if.sv
// Read port between the waveform display and the waveform sample store.
// The display side is master: it drives the column address and the read enable.
interface wave_display_if;
  logic       wave_data_req;
  logic [8:0] wave_rd_addr;
  logic [7:0] wave_rd_data;

  modport master (
    output wave_data_req,
    output wave_rd_addr,
    input  wave_rd_data
  );

  modport slave (
    input  wave_data_req,
    input  wave_rd_addr,
    output wave_rd_data
  );
endinterface

// File: rtl/wave_display.sv
// Renders a 300x256 RGB565 waveform window from stored samples, three pixel clocks
// after each coordinate arrives, and flags frame completion for the capture side.
module wave_display #(
  parameter logic [10:0] WAVE_X0 = 11'd50,
  parameter logic [10:0] WAVE_Y0 = 11'd100,
  parameter logic [15:0] C_BG    = 16'h0000,
  parameter logic [15:0] C_GRID  = 16'h8410,
  parameter logic [15:0] C_TRIG  = 16'hF800,
  parameter logic [15:0] C_WAVE  = 16'hFFE0
) (
  input  logic                  lcd_clk,
  input  logic                  rst_n,
  input  logic [10:0]           pixel_xpos,
  input  logic [10:0]           pixel_ypos,
  input  logic [7:0]            trig_level,
  wave_display_if.master        wave_if,
  output logic [15:0]           pixel_data,
  output logic                  lcd_wr_over
);

  localparam logic [10:0] X_LAST = WAVE_X0 + 11'd299;
  localparam logic [10:0] Y_LAST = WAVE_Y0 + 11'd255;

  typedef enum logic [1:0] {
    WAIT_AREA,
    DRAW,
    OVER
  } state_t;

  logic       w_inArea;
  logic [8:0] w_col;
  logic [7:0] w_row;
  logic       w_grid;
  logic       w_trig;

  logic       r_rdReq;
  logic [8:0] r_rdAddr;

  logic       r_s1InArea;
  logic [8:0] r_s1Col;
  logic [7:0] r_s1Row;
  logic       r_s1Grid;
  logic       r_s1Trig;

  logic       r_s2InArea;
  logic [8:0] r_s2Col;
  logic [7:0] r_s2Row;
  logic       r_s2Grid;
  logic       r_s2Trig;
  logic [7:0] r_s2YCur;
  logic [7:0] r_s2YPrev;

  logic       r_s3InArea;
  logic [8:0] r_s3Col;
  logic [7:0] r_s3Row;

  logic [7:0] w_yLo;
  logic [7:0] w_yHi;
  logic       w_trace;
  logic [15:0] w_colour;

  state_t     r_state;

  // Window offsets only need their low bits; the full-width compares guard against wrap.
  assign w_inArea = (pixel_xpos >= WAVE_X0) && (pixel_xpos <= X_LAST) &&
                    (pixel_ypos >= WAVE_Y0) && (pixel_ypos <= Y_LAST);
  assign w_col    = pixel_xpos[8:0] - WAVE_X0[8:0];
  assign w_row    = pixel_ypos[7:0] - WAVE_Y0[7:0];

  assign w_grid = (w_col == 9'd0) || (w_col == 9'd299) ||
                  (w_row == 8'd0) || (w_row == 8'd255) ||
                  (((w_col % 9'd25) == 9'd0) && (w_row[1:0] == 2'b00)) ||
                  ((w_row[4:0] == 5'd0) && (w_col[1:0] == 2'b00));
  assign w_trig = (w_row == (8'd255 - trig_level));

  assign wave_if.wave_data_req = r_rdReq;
  assign wave_if.wave_rd_addr  = r_rdAddr;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdReq    <= 1'b0;
      r_rdAddr   <= 9'd0;
      r_s1InArea <= 1'b0;
      r_s1Col    <= 9'd0;
      r_s1Row    <= 8'd0;
      r_s1Grid   <= 1'b0;
      r_s1Trig   <= 1'b0;
    end else begin
      r_rdReq    <= w_inArea;
      if (w_inArea) begin
        r_rdAddr <= w_col;
      end
      r_s1InArea <= w_inArea;
      r_s1Col    <= w_col;
      r_s1Row    <= w_row;
      r_s1Grid   <= w_grid;
      r_s1Trig   <= w_trig;
    end
  end

  // The previous sample only counts as the segment start if it sat in this same window row.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2InArea <= 1'b0;
      r_s2Col    <= 9'd0;
      r_s2Row    <= 8'd0;
      r_s2Grid   <= 1'b0;
      r_s2Trig   <= 1'b0;
      r_s2YCur   <= 8'd0;
      r_s2YPrev  <= 8'd0;
    end else begin
      r_s2InArea <= r_s1InArea;
      r_s2Col    <= r_s1Col;
      r_s2Row    <= r_s1Row;
      r_s2Grid   <= r_s1Grid;
      r_s2Trig   <= r_s1Trig;
      r_s2YCur   <= wave_if.wave_rd_data;
      if (r_s2InArea && r_s1InArea && (r_s2Row == r_s1Row)) begin
        r_s2YPrev <= r_s2YCur;
      end else begin
        r_s2YPrev <= wave_if.wave_rd_data;
      end
    end
  end

  assign w_yLo   = (r_s2YPrev < r_s2YCur) ? r_s2YPrev : r_s2YCur;
  assign w_yHi   = (r_s2YPrev < r_s2YCur) ? r_s2YCur : r_s2YPrev;
  assign w_trace = (r_s2YCur != 8'd255) && (r_s2YPrev != 8'd255) &&
                   (r_s2Row >= w_yLo) && (r_s2Row <= w_yHi);

  always_comb begin
    w_colour = C_BG;
    if (!r_s2InArea) begin
      w_colour = C_BG;
    end else if (w_trace) begin
      w_colour = C_WAVE;
    end else if (r_s2Trig) begin
      w_colour = C_TRIG;
    end else if (r_s2Grid) begin
      w_colour = C_GRID;
    end
  end

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data <= C_BG;
      r_s3InArea <= 1'b0;
      r_s3Col    <= 9'd0;
      r_s3Row    <= 8'd0;
    end else begin
      pixel_data <= w_colour;
      r_s3InArea <= r_s2InArea;
      r_s3Col    <= r_s2Col;
      r_s3Row    <= r_s2Row;
    end
  end

  // Frame tracking follows the rendered pixel; a new frame edge from the driver aborts or re-arms.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_AREA;
      lcd_wr_over <= 1'b0;
    end else begin
      lcd_wr_over <= 1'b0;
      case (r_state)
        WAIT_AREA: begin
          if (r_s3InArea && (r_s3Col == 9'd0) && (r_s3Row == 8'd0)) begin
            r_state <= DRAW;
          end
        end
        DRAW: begin
          if (r_s3InArea && (r_s3Col == 9'd299) && (r_s3Row == 8'd255)) begin
            r_state     <= OVER;
            lcd_wr_over <= 1'b1;
          end else if (pixel_ypos == 11'd0) begin
            r_state <= WAIT_AREA;
          end
        end
        OVER: begin
          if (pixel_ypos == 11'd0) begin
            r_state <= WAIT_AREA;
          end else begin
            lcd_wr_over <= 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_AREA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_display.sv
// Bench for wave_display: raster scans over randomised sample memories, scored
// against a pixel-level reference of the window, trace, trigger and grid rules.
module tb_wave_display;

  localparam logic [15:0] C_BG   = 16'h0000;
  localparam logic [15:0] C_GRID = 16'h8410;
  localparam logic [15:0] C_TRIG = 16'hF800;
  localparam logic [15:0] C_WAVE = 16'hFFE0;

  logic        lcd_clk = 1'b0;
  logic        rst_n;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [7:0]  trig_level;
  logic [15:0] pixel_data;
  logic        lcd_wr_over;

  wave_display_if wif ();

  logic [7:0] mem [512];
  assign wif.wave_rd_data = mem[wif.wave_rd_addr];

  wave_display dut (
    .lcd_clk     (lcd_clk),
    .rst_n       (rst_n),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .trig_level  (trig_level),
    .wave_if     (wif),
    .pixel_data  (pixel_data),
    .lcd_wr_over (lcd_wr_over)
  );

  always #5 lcd_clk = ~lcd_clk;

  int cyc = 0;
  always @(posedge lcd_clk) cyc <= cyc + 1;

  typedef struct { int due; int x; int y; logic [15:0] pix; } pixItem_t;
  typedef struct { int due; logic req; logic [8:0] addr; } s1Item_t;
  typedef struct { int at; logic val; } overEv_t;

  pixItem_t pixQ[$];
  s1Item_t  s1Q[$];
  overEv_t  overQ[$];
  int       rowList[$];

  int       checks = 0;
  int       errors = 0;
  logic     prevValid = 1'b0;
  int       prevX = 0;
  int       prevY = 0;
  logic     drawing = 1'b0;
  logic     expOver = 1'b0;
  logic [8:0] lastAddr = 9'd0;

  task automatic checkOutput(input string name, input int x, input int y,
                             input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (x=%0d y=%0d): got %h, expected %h", name, x, y, act, exp);
    end
  endtask

  function automatic logic inWin(input int x, input int y);
    return (x >= 50) && (x <= 349) && (y >= 100) && (y <= 355);
  endfunction

  // Reference colour of one window pixel, given the pixel presented just before it.
  function automatic logic [15:0] refColour(input int x, input int y);
    int col, row, yc, yp, lo, hi;
    if (!inWin(x, y)) return C_BG;
    col = x - 50;
    row = y - 100;
    yc  = int'(mem[col]);
    yp  = yc;
    if (prevValid && inWin(prevX, prevY) && (prevY == y)) yp = int'(mem[prevX - 50]);
    lo = (yp < yc) ? yp : yc;
    hi = (yp < yc) ? yc : yp;
    if (yc != 255 && yp != 255 && row >= lo && row <= hi) return C_WAVE;
    if (row == 255 - int'(trig_level)) return C_TRIG;
    if (col == 0 || col == 299 || row == 0 || row == 255) return C_GRID;
    if ((col % 25 == 0 && row % 4 == 0) || (row % 32 == 0 && col % 4 == 0)) return C_GRID;
    return C_BG;
  endfunction

  task automatic applyStimulus(input int x, input int y);
    pixItem_t p;
    s1Item_t  s;
    overEv_t  e;
    @(negedge lcd_clk);
    #1;
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    p.due = cyc + 3; p.x = x; p.y = y; p.pix = refColour(x, y);
    pixQ.push_back(p);
    if (inWin(x, y)) lastAddr = 9'(x - 50);
    s.due = cyc + 1; s.req = inWin(x, y); s.addr = lastAddr;
    s1Q.push_back(s);
    if (y == 0) begin
      drawing = 1'b0;
      e.at = cyc + 1; e.val = 1'b0;
      overQ.push_back(e);
    end
    if (x == 50 && y == 100) drawing = 1'b1;
    if (x == 349 && y == 355 && drawing) begin
      e.at = cyc + 4; e.val = 1'b1;
      overQ.push_back(e);
      drawing = 1'b0;
    end
    prevValid = 1'b1;
    prevX = x;
    prevY = y;
  endtask

  task automatic scanRow(input int y, input int xEnd);
    for (int x = 40; x <= xEnd; x++) applyStimulus(x, y);
  endtask

  task automatic scanFrame();
    foreach (rowList[i]) scanRow(rowList[i], 360);
  endtask

  task automatic resetPulse();
    @(negedge lcd_clk);
    #1;
    rst_n = 1'b0;
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd400;
    pixQ.delete();
    s1Q.delete();
    overQ.delete();
    expOver = 1'b0;
    drawing = 1'b0;
    prevValid = 1'b0;
    lastAddr = 9'd0;
    #1;
    checkOutput("rst_pixel", -1, -1, pixel_data, C_BG);
    checkOutput("rst_req", -1, -1, {15'd0, wif.wave_data_req}, 16'd0);
    checkOutput("rst_addr", -1, -1, {7'd0, wif.wave_rd_addr}, 16'd0);
    checkOutput("rst_wr_over", -1, -1, {15'd0, lcd_wr_over}, 16'd0);
    repeat (2) @(negedge lcd_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fillFlat(input int v);
    for (int c = 0; c < 512; c++) mem[c] = 8'(v);
  endtask

  task automatic fillRandom();
    for (int c = 0; c < 512; c++) mem[c] = 8'($urandom_range(0, 254));
    mem[20]  = 8'd255;
    mem[150] = 8'd255;
  endtask

  task automatic addRandomRows(input int n);
    for (int i = 0; i < n; i++) rowList.push_back($urandom_range(101, 354));
  endtask

  always @(negedge lcd_clk) begin
    overEv_t  ev;
    pixItem_t pItem;
    s1Item_t  sItem;
    while (overQ.size() > 0 && overQ[0].at <= cyc) begin
      ev = overQ.pop_front();
      expOver = ev.val;
    end
    if (rst_n) checkOutput("wr_over", cyc, 0, {15'd0, lcd_wr_over}, {15'd0, expOver});
    if (pixQ.size() > 0 && pixQ[0].due <= cyc) begin
      pItem = pixQ.pop_front();
      checkOutput("pixel", pItem.x, pItem.y, pixel_data, pItem.pix);
    end
    if (s1Q.size() > 0 && s1Q[0].due <= cyc) begin
      sItem = s1Q.pop_front();
      checkOutput("rd_req", cyc, 0, {15'd0, wif.wave_data_req}, {15'd0, sItem.req});
      checkOutput("rd_addr", cyc, 0, {7'd0, wif.wave_rd_addr}, {7'd0, sItem.addr});
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL timeout: bench did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    pixel_xpos = 11'd0;
    pixel_ypos = 11'd400;
    trig_level = 8'd0;
    fillFlat(128);
    repeat (3) @(negedge lcd_clk);
    #1;
    checkOutput("init_pixel", -1, -1, pixel_data, C_BG);
    checkOutput("init_req", -1, -1, {15'd0, wif.wave_data_req}, 16'd0);
    checkOutput("init_addr", -1, -1, {7'd0, wif.wave_rd_addr}, 16'd0);
    checkOutput("init_wr_over", -1, -1, {15'd0, lcd_wr_over}, 16'd0);
    rst_n = 1'b1;

    // Flat trace at 128, trigger line on the bottom border row.
    rowList = '{0, 99, 100, 101, 132, 164};
    addRandomRows(3);
    rowList.push_back(227); rowList.push_back(228); rowList.push_back(229);
    rowList.push_back(354); rowList.push_back(355); rowList.push_back(356);
    rowList.push_back(400);
    scanFrame();

    // Step from 200 down to 50 at column 10.
    for (int c = 0; c < 512; c++) mem[c] = (c < 10) ? 8'd200 : 8'd50;
    trig_level = 8'($urandom_range(0, 255));
    rowList = '{0, 100, 149, 150, 151, 250, 299, 300, 301, 355, 400};
    scanFrame();

    // Random samples with out-of-range columns.
    fillRandom();
    trig_level = 8'($urandom_range(0, 255));
    rowList = '{0, 100};
    addRandomRows(8);
    rowList.push_back(355);
    rowList.push_back(400);
    scanFrame();

    // Truncated frame: driver restarts before the window finishes.
    rowList = '{0, 100, 150, 200};
    scanFrame();

    // Reset in the middle of a trace row, then the rest of that frame.
    fillFlat(128);
    trig_level = 8'd64;
    rowList = '{0, 100, 160};
    scanFrame();
    scanRow(228, 200);
    resetPulse();
    rowList = '{300, 355, 400};
    scanFrame();

    // Full frame after reset, then reset while the frame-done flag is high.
    rowList = '{0, 100, 200, 228, 355, 400};
    scanFrame();
    for (int i = 0; i < 10; i++) applyStimulus(0, 400);
    resetPulse();

    // Final random frame.
    fillRandom();
    trig_level = 8'($urandom_range(0, 255));
    rowList = '{0, 100};
    addRandomRows(6);
    rowList.push_back(355);
    rowList.push_back(400);
    scanFrame();
    for (int i = 0; i < 6; i++) applyStimulus(0, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
